bram_port_arbiter: RTL
======================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 18, BRAM word address width.
REQ-002 Parameter DATA_W, default 16, BRAM word width (RGB565 pixel).
REQ-003 Parameter STARVE_LIMIT, default 255, count of consecutive ungranted pending cycles that raises the starvation flag.
REQ-004 CLK  in  1  single clock for all logic; BRAM runs on CLK.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 vid_req  in  1  scanout read request for this cycle; no ack; fire-and-forget.
REQ-007 vid_addr  in  ADDR_W  scanout read address.
REQ-008 vid_valid  out  1  scanout read data valid.
REQ-009 vid_data  out  DATA_W  scanout read data.
REQ-010 wr_req  in  1  writer request; held with wr_addr/wr_data until wr_ack.
REQ-011 wr_addr  in  ADDR_W  write address.
REQ-012 wr_data  in  DATA_W  write data.
REQ-013 wr_ack  out  1  one-cycle pulse: write issued to BRAM.
REQ-014 rd_req  in  1  host read request; held with rd_addr until rd_ack.
REQ-015 rd_addr  in  ADDR_W  host read address.
REQ-016 rd_ack  out  1  one-cycle pulse: host read issued to BRAM.
REQ-017 rd_valid  out  1  host read data valid.
REQ-018 rd_data  out  DATA_W  host read data.
REQ-019 BRAMEN  out  1  BRAM port enable.
REQ-020 BRAMWE  out  1  BRAM write enable.
REQ-021 BRAMADDR  out  ADDR_W  BRAM address.
REQ-022 BRAMDIN  out  DATA_W  BRAM write data.
REQ-023 BRAMDOUT  in  DATA_W  BRAM read data, valid one cycle after BRAMEN with BRAMWE low.
REQ-024 starve  out  1  a pending wr or rd request has waited >= STARVE_LIMIT cycles.

Function
REQ-025 Arbitration in cycle N from sampled requests; priority: vid_req strictly highest; wr/rd share the remaining slot round-robin.
REQ-026 Round-robin pointer: after a wr grant, rd preferred next; after an rd grant, wr preferred next; pointer unchanged by video grants or idle cycles; reset value prefers wr.
REQ-027 A requester whose ack is high in the current cycle is masked from arbitration that cycle (no double issue of one held request).
REQ-028 BRAMEN, BRAMWE, BRAMADDR, BRAMDIN registered: command issued in cycle N+1 for a grant in cycle N.
REQ-029 Idle cycle (no eligible request): BRAMEN=0, BRAMWE=0 in N+1; BRAMADDR/BRAMDIN hold previous values.
REQ-030 wr grant: N+1 has BRAMEN=1, BRAMWE=1, BRAMADDR=wr_addr, BRAMDIN=wr_data, wr_ack=1.
REQ-031 rd grant: N+1 has BRAMEN=1, BRAMWE=0, BRAMADDR=rd_addr, rd_ack=1; N+2 has rd_valid=1, rd_data=BRAMDOUT.
REQ-032 vid grant: N+1 has BRAMEN=1, BRAMWE=0, BRAMADDR=vid_addr; N+2 has vid_valid=1, vid_data=BRAMDOUT.
REQ-033 Read-return owner tracked by a 2-stage tag pipeline (none/vid/rd); exactly one of vid_valid/rd_valid per issued read; vid_data/rd_data hold last value when not valid.
REQ-034 Back-to-back video requests every cycle: full throughput, one vid_valid per cycle, order preserved, wr/rd receive no grants.
REQ-035 Per-port wait counters (wr, rd): increment each cycle the request is pending, unmasked and not granted; clear on grant or when req drops; saturate at STARVE_LIMIT.
REQ-036 starve = (wr counter == STARVE_LIMIT) OR (rd counter == STARVE_LIMIT), registered; deasserts the cycle after the counter clears.
REQ-037 Write followed by read to the same address: read issued later returns the new data (BRAM read-first/write-first irrelevant, accesses never share a cycle).

Reset
REQ-038 RESET high forces immediately: all outputs 0, wait counters 0, tag pipeline empty, RR pointer to wr.
REQ-039 Reset mid-operation: in-flight reads dropped; no vid_valid/rd_valid after RESET deasserts for reads issued before reset; held wr/rd requests re-arbitrate normally after release.

Verification
REQ-040 Single write: wr_req=1, wr_addr=0x00010, wr_data=0xF800 at N -> N+1 BRAMEN=1, BRAMWE=1, BRAMADDR=0x00010, BRAMDIN=0xF800, wr_ack=1; no second ack while req held through N+1.
REQ-041 Read-after-write: then rd_req, rd_addr=0x00010 -> rd_ack one cycle later, rd_valid with rd_data=0xF800 one cycle after rd_ack.
REQ-042 Video priority: vid_req=1 for 640 consecutive cycles, wr_req held -> 640 vid_valid in address order, wr_ack only in cycle after vid_req drops.
REQ-043 Fairness: wr_req and rd_req held continuously, no video -> acks alternate wr, rd, wr, rd (first wr after reset).
REQ-044 Starvation: STARVE_LIMIT=4, vid_req continuous, wr_req held -> starve=1 after 4 waiting cycles; vid_req drops -> wr_ack, starve=0 next cycle.
REQ-045 Reset mid-read: vid_req at N, RESET pulse at N+1 -> no vid_valid at N+2; all outputs 0 during reset.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Single-port BRAM arbiter: video scanout reads take strict priority, and the
// writer and host reader share the remaining slots round-robin. Commands are
// registered one cycle after the grant, and reads return one cycle after that.
module bram_port_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              BRAMEN,
  output logic              BRAMWE,
  output logic [ADDR_W-1:0] BRAMADDR,
  output logic [DATA_W-1:0] BRAMDIN,
  input  logic [DATA_W-1:0] BRAMDOUT,
  output logic              starve
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_WR, GNT_RD} gnt_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_RD} tag_t;

  logic              r_bram_en;
  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [DATA_W-1:0] r_bram_din;
  logic              r_wr_ack;
  logic              r_rd_ack;
  logic              r_rr_wr;      // 1: writer wins the next wr/rd tie
  tag_t              r_tag1;       // owner of the read currently at the BRAM
  tag_t              r_tag2;       // owner of the data currently on BRAMDOUT
  logic [DATA_W-1:0] r_vid_data;
  logic [DATA_W-1:0] r_rd_data;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic              r_starve;

  logic              w_wr_elig;
  logic              w_rd_elig;
  gnt_t              w_gnt;
  tag_t              w_tag_nxt;
  logic [CNT_W-1:0]  w_wr_cnt_nxt;
  logic [CNT_W-1:0]  w_rd_cnt_nxt;

  // Grant selection: video first, then round-robin between writer and reader.
  // A requester acked this cycle is still holding its old request, so it is masked.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_gnt     = GNT_NONE;
    w_wr_elig = wr_req && !r_wr_ack;
    w_rd_elig = rd_req && !r_rd_ack;
    if (vid_req)                                w_gnt = GNT_VID;
    else if (w_wr_elig && (r_rr_wr || !w_rd_elig)) w_gnt = GNT_WR;
    else if (w_rd_elig)                         w_gnt = GNT_RD;
  end

  // Read-return tag for the command being issued, plus saturating wait counters.
  always_comb begin
    w_tag_nxt    = TAG_NONE;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    if (w_gnt == GNT_VID)     w_tag_nxt = TAG_VID;
    else if (w_gnt == GNT_RD) w_tag_nxt = TAG_RD;

    if (!wr_req || w_gnt == GNT_WR)        w_wr_cnt_nxt = '0;
    else if (w_wr_elig && r_wr_cnt != LIMIT_C) w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);

    if (!rd_req || w_gnt == GNT_RD)        w_rd_cnt_nxt = '0;
    else if (w_rd_elig && r_rd_cnt != LIMIT_C) w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
  end

  // Registered BRAM command, acks and round-robin pointer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bram_en   <= 1'b0;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_rr_wr     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      r_bram_en <= (w_gnt != GNT_NONE);
      r_bram_we <= (w_gnt == GNT_WR);
      r_wr_ack  <= (w_gnt == GNT_WR);
      r_rd_ack  <= (w_gnt == GNT_RD);
      // Address and write data hold their previous values on idle cycles.
      case (w_gnt)
        GNT_VID: r_bram_addr <= vid_addr;
        GNT_WR: begin
          r_bram_addr <= wr_addr;
          r_bram_din  <= wr_data;
          r_rr_wr     <= 1'b0;
        end
        GNT_RD: begin
          r_bram_addr <= rd_addr;
          r_rr_wr     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Two-stage owner pipeline and held read data for each read port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tag1     <= TAG_NONE;
      r_tag2     <= TAG_NONE;
      r_vid_data <= '0;
      r_rd_data  <= '0;
    end else begin
      r_tag1 <= w_tag_nxt;
      r_tag2 <= r_tag1;
      if (r_tag2 == TAG_VID) r_vid_data <= BRAMDOUT;
      if (r_tag2 == TAG_RD)  r_rd_data  <= BRAMDOUT;
    end
  end

  // Wait counters and the registered starvation flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_starve <= 1'b0;
    end else begin
      r_wr_cnt <= w_wr_cnt_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_starve <= (r_wr_cnt == LIMIT_C) || (r_rd_cnt == LIMIT_C);
    end
  end

  // BRAMDOUT is presented directly in the return cycle; otherwise the last value holds.
  assign vid_valid = (r_tag2 == TAG_VID);
  assign rd_valid  = (r_tag2 == TAG_RD);
  assign vid_data  = vid_valid ? BRAMDOUT : r_vid_data;
  assign rd_data   = rd_valid  ? BRAMDOUT : r_rd_data;
  assign BRAMEN    = r_bram_en;
  assign BRAMWE    = r_bram_we;
  assign BRAMADDR  = r_bram_addr;
  assign BRAMDIN   = r_bram_din;
  assign wr_ack    = r_wr_ack;
  assign rd_ack    = r_rd_ack;
  assign starve    = r_starve;

endmodule
